clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-setting controller for the clock display. It consumes the single-cycle pulses produced by the three button debouncers (mode, up, down) and sequences a set-mode state machine over the hour, minute and second fields. It maintains editable copies of the fields and commits them to the timekeeping counters with a one-cycle load strobe. It aborts back to run mode after a period of button inactivity.

## Interface

- `TICK_DIV`, default 50000000: clk cycles per 1 s timeout/blink period (50 MHz board clock).
- `TIMEOUT_S`, default 10: idle seconds in a set state before abort.
- `clk` in, 1: system clock, 50 MHz.
- `rst` in, 1: synchronous, active-high reset.
- `mode_p` in, 1: debounced mode button pulse, one clk wide.
- `up_p` in, 1: debounced up button pulse, one clk wide.
- `down_p` in, 1: debounced down button pulse, one clk wide.
- `cur_hh` in, 5: current hours, binary 0..23.
- `cur_mm` in, 6: current minutes, binary 0..59.
- `cur_ss` in, 6: current seconds, binary 0..59.
- `set_active` out, 1: high in any set state.
- `field_sel` out, 2: field being edited. 0 = none, 1 = hh, 2 = mm, 3 = ss.
- `edit_hh` out, 5: edited hours.
- `edit_mm` out, 6: edited minutes.
- `edit_ss` out, 6: edited seconds.
- `load_p` out, 1: one-cycle commit strobe. `edit_*` are valid in the same cycle.
- `blink` out, 1: display blink enable for the selected field.

## Operation

- States: RUN, SET_HH, SET_MM, SET_SS, COMMIT.
- RUN:
  - On `mode_p`, capture `cur_hh/mm/ss` into `edit_*` and go to SET_HH.
  - `up_p` and `down_p` are ignored.
- SET_HH, SET_MM and SET_SS:
  - `mode_p` advances to the next state: SET_HH -> SET_MM -> SET_SS -> COMMIT.
  - `up_p` increments the selected field. Hours wrap 23 -> 0; minutes and seconds wrap 59 -> 0.
  - `down_p` decrements the selected field. Hours wrap 0 -> 23; minutes and seconds wrap 0 -> 59.
- Simultaneous pulses:
  - `mode_p` has priority over `up_p`/`down_p` in the same cycle; the field is not changed.
  - `up_p` and `down_p` together (without mode) is a no-op, but still counts as activity.
- COMMIT: lasts one cycle. `load_p` = 1, then the state returns to RUN unconditionally. Pulses arriving during COMMIT are ignored.
- Timeout:
  - A 1 s tick comes from a prescaler counting 0..`TICK_DIV`-1.
  - An idle-seconds counter increments on each tick while in a set state.
  - Any `mode_p`, `up_p` or `down_p` in a set state clears both the prescaler and the idle counter.
  - When the idle counter reaches `TIMEOUT_S`, go to RUN with no `load_p` (abort).
  - `edit_*` keep their values after an abort.
- Blink: in set states, `blink` = 1 while the prescaler is below `TICK_DIV`/2, else 0. `blink` = 0 in RUN and COMMIT.
- Prescaler and idle counter are held at 0 in RUN and COMMIT.
- `field_sel` maps state to field: RUN/COMMIT = 0, SET_HH = 1, SET_MM = 2, SET_SS = 3.
- `set_active` is high for SET_* states only.
- Out-of-range `cur_*` values are captured as-is. The first increment of an out-of-range value wraps it to 0; the first decrement yields the maximum legal value.

## Timing

- All outputs are registered.
- An input pulse in cycle N is reflected in the outputs in cycle N+1.
- `mode_p` in RUN at cycle N: at N+1, state = SET_HH, `field_sel` = 1, `edit_*` equal `cur_*` sampled at N, `blink` = 1.
- `mode_p` in SET_SS at N: `load_p` = 1 at N+1 only; RUN at N+2.
- Timeout abort fires exactly `TIMEOUT_S`×`TICK_DIV` cycles after entry or after the last pulse.
- Reset (including mid-edit or during COMMIT), values from the next cycle:
  - state = RUN
  - `set_active` = 0, `field_sel` = 0, `load_p` = 0, `blink` = 0
  - `edit_hh/mm/ss` = 0
  - prescaler and idle counter = 0
- Reset takes priority over all pulses in the same cycle.

## Test plan

Benches use `TICK_DIV` = 8, `TIMEOUT_S` = 3.

1. Enter set mode and commit:
   - Stimulus: `cur` = 12:34:56; `mode_p`; 2× `up_p`; `mode_p`; 1× `down_p`; `mode_p`; `mode_p`.
   - Required: one `load_p` with `edit` = 14:33:56; then RUN, `field_sel` = 0.
2. Wrap-around:
   - Hours: `edit_hh` = 23 then `up_p` -> 0; then `down_p` -> 23.
   - Minutes: `edit_mm` = 0 then `down_p` -> 59; then `up_p` -> 0.
3. Simultaneous pulses:
   - `up_p` + `down_p` in the same cycle in SET_MM -> `edit_mm` unchanged.
   - `mode_p` + `up_p` in SET_HH -> SET_MM, `edit_hh` unchanged.
4. Timeout:
   - Stimulus: enter SET_HH and apply no pulses.
   - Required: RUN after exactly 24 cycles, `load_p` never asserted.
   - Variant: an `up_p` at cycle 20 restarts the count; abort occurs 24 cycles after that pulse.
5. Blink:
   - In SET_SS, `blink` shows a 4-high / 4-low pattern with an 8-cycle period, restarting high after any pulse.
   - `blink` = 0 in RUN.
6. Reset mid-operation:
   - `rst` asserted in SET_MM, and separately in the COMMIT cycle.
   - Required: all outputs 0 and state RUN on the next cycle; no further `load_p`.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - button pulse, current time and edit/commit signal bundle for clock_set_ctrl
interface clock_set_ctrl_if;
  logic       mode_p;
  logic       up_p;
  logic       down_p;
  logic [4:0] cur_hh;
  logic [5:0] cur_mm;
  logic [5:0] cur_ss;
  logic       set_active;
  logic [1:0] field_sel;
  logic [4:0] edit_hh;
  logic [5:0] edit_mm;
  logic [5:0] edit_ss;
  logic       load_p;
  logic       blink;

  modport master (
    output mode_p, up_p, down_p, cur_hh, cur_mm, cur_ss,
    input  set_active, field_sel, edit_hh, edit_mm, edit_ss, load_p, blink
  );

  modport slave (
    input  mode_p, up_p, down_p, cur_hh, cur_mm, cur_ss,
    output set_active, field_sel, edit_hh, edit_mm, edit_ss, load_p, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - set-mode sequencer editing hh/mm/ss with commit strobe, idle abort and blink
module clock_set_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int TIMEOUT_S = 10
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(TIMEOUT_S + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLINK_LIM  = PW'(TICK_DIV / 2);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_S - 1);

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_SET_HH = 3'd1;
  localparam logic [2:0] S_SET_MM = 3'd2;
  localparam logic [2:0] S_SET_SS = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]    state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [IW-1:0] idle, idle_n;
  logic [4:0]    hh, hh_n;
  logic [5:0]    mm, mm_n;
  logic [5:0]    ss, ss_n;

  logic       set_active_q;
  logic [1:0] field_sel_q;
  logic       load_q;
  logic       blink_q;

  logic       in_set;
  logic       activity;
  logic       step_en;
  logic       step_up;
  logic       set_n;

  // Out-of-range values fold onto the legal range on their first step.
  function automatic logic [4:0] step_hh(input logic [4:0] v, input logic inc);
    if (inc)
      return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] step_60(input logic [5:0] v, input logic inc);
    if (inc)
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
  endfunction

  assign in_set   = (state == S_SET_HH) || (state == S_SET_MM) || (state == S_SET_SS);
  assign activity = bus.mode_p || bus.up_p || bus.down_p;
  assign step_en  = !bus.mode_p && (bus.up_p != bus.down_p);
  assign step_up  = bus.up_p;

  always_comb begin
    state_n = state;
    presc_n = presc;
    idle_n  = idle;
    hh_n    = hh;
    mm_n    = mm;
    ss_n    = ss;

    case (state)
      S_RUN: begin
        presc_n = '0;
        idle_n  = '0;
        if (bus.mode_p) begin
          state_n = S_SET_HH;
          hh_n    = bus.cur_hh;
          mm_n    = bus.cur_mm;
          ss_n    = bus.cur_ss;
        end
      end

      S_SET_HH, S_SET_MM, S_SET_SS: begin
        if (activity) begin
          presc_n = '0;
          idle_n  = '0;
          if (bus.mode_p) begin
            case (state)
              S_SET_HH: state_n = S_SET_MM;
              S_SET_MM: state_n = S_SET_SS;
              default:  state_n = S_COMMIT;
            endcase
          end else if (step_en) begin
            case (state)
              S_SET_HH: hh_n = step_hh(hh, step_up);
              S_SET_MM: mm_n = step_60(mm, step_up);
              default:  ss_n = step_60(ss, step_up);
            endcase
          end
        end else if (presc == PRESC_LAST) begin
          presc_n = '0;
          // Last idle second elapsed: abandon the edit without committing.
          if (idle == IDLE_LAST) begin
            state_n = S_RUN;
            idle_n  = '0;
          end else begin
            idle_n = idle + IW'(1);
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end

      default: begin
        state_n = S_RUN;
        presc_n = '0;
        idle_n  = '0;
      end
    endcase
  end

  assign set_n = (state_n == S_SET_HH) || (state_n == S_SET_MM) || (state_n == S_SET_SS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      presc        <= '0;
      idle         <= '0;
      hh           <= '0;
      mm           <= '0;
      ss           <= '0;
      set_active_q <= 1'b0;
      field_sel_q  <= 2'd0;
      load_q       <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      idle         <= idle_n;
      hh           <= hh_n;
      mm           <= mm_n;
      ss           <= ss_n;
      set_active_q <= set_n;
      field_sel_q  <= set_n ? state_n[1:0] : 2'd0;
      load_q       <= (state_n == S_COMMIT);
      blink_q      <= set_n && (presc_n < BLINK_LIM);
    end
  end

  assign bus.set_active = set_active_q;
  assign bus.field_sel  = field_sel_q;
  assign bus.edit_hh    = hh;
  assign bus.edit_mm    = mm;
  assign bus.edit_ss    = ss;
  assign bus.load_p     = load_q;
  assign bus.blink      = blink_q;

endmodule
